io_responder: RTL and testbench

Memory-mapped I/O peripheral that answers the CPU's MEM-stage I/O accesses and drives the CPU interrupt line. It buffers inbound words from an external producer in a FIFO, exposes data, status and control registers to loads and stores, and presents an outbound data register with a valid/ready handshake. It runs the intr/intr_ack request handshake toward the CPU's Control Unit. The top level decodes the memory control word into io_cs/io_rd/io_wr.

---
 rtl/io_responder.sv | 112 +++++++++++
 tb/tb_io_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O peripheral with inbound FIFO, outbound data register and interrupt handshake.
module io_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] io_out,
    output logic              intr,
    input  logic              intr_ack,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr, rptr, count;
    logic              ie, underflow, overflow, empty, full;
    logic              rd, wr, pop, push, flush, ctrl_wr, dout_wr;
    logic [1:0]        sel;
    logic [DATA_W-1:0] status;
    logic              unused;

    assign unused  = ^{addr[31:4], addr[1:0], wdata[DATA_W-1:3]};
    assign sel     = addr[3:2];
    assign rd      = io_cs && io_rd;
    assign wr      = io_cs && io_wr;
    assign ctrl_wr = wr && sel == 2'd3;
    assign dout_wr = wr && sel == 2'd1;
    assign flush   = ctrl_wr && wdata[1];
    assign count   = wptr - rptr;
    assign empty   = wptr == rptr;
    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign full    = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
    assign in_ready = !full;
    assign push    = in_valid && in_ready;
    assign pop     = rd && sel == 2'd0 && !empty;
    assign intr    = state == REQ;
    assign status  = {{(DATA_W-AW-7){1'b0}}, count, underflow, overflow, out_valid, full, empty, ie};

    always_comb begin
        io_out = !rd           ? '0 :
                 sel == 2'd0   ? (empty ? '0 : mem[rptr[AW-1:0]]) :
                 sel == 2'd1   ? out_data :
                 sel == 2'd2   ? status :
                                 {{(DATA_W-1){1'b0}}, ie};
    end

    always_comb begin
        state_nx = state == IDLE ? ((ie && !empty) ? REQ : IDLE) :
                   state == REQ  ? (intr_ack ? SERVICE : (!ie ? IDLE : REQ)) :
                                   ((empty || !ie) ? IDLE : SERVICE);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            ie        <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)
                    wptr <= wptr + (AW+1)'(1);
                if (pop)
                    rptr <= rptr + (AW+1)'(1);
            end
            if (ctrl_wr)
                ie <= wdata[0];
            if (ctrl_wr && wdata[2]) begin
                underflow <= 1'b0;
                overflow  <= 1'b0;
            end
            if (rd && sel == 2'd0 && empty)
                underflow <= 1'b1;
            // A store may land in the same cycle the consumer takes the old word.
            if (dout_wr && out_valid && !out_ready)
                overflow <= 1'b1;
            if (dout_wr && !(out_valid && !out_ready)) begin
                out_data  <= wdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed vector table plus hand sequences for io_responder.
module tb_io_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        io_cs = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
    logic        intr_ack = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] addr = '0, wdata = '0, in_data = '0;
    logic [31:0] io_out, out_data;
    logic        intr, in_ready, out_valid;
    int          checks = 0, failures = 0;

    typedef struct {
        bit          rd;
        logic [1:0]  sel;
        bit          iv;
        logic [31:0] idata;
        logic [31:0] exp_out;
        bit          exp_rdy;
    } vec_t;

    vec_t v[20];

    io_responder #(.DATA_W(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .addr(addr), .wdata(wdata), .io_out(io_out), .intr(intr), .intr_ack(intr_ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        io_cs = 0; io_rd = 0; io_wr = 0; in_valid = 0; intr_ack = 0;
    endtask

    task automatic acc(bit r, bit w, logic [1:0] s, logic [31:0] d);
        io_cs = r | w; io_rd = r; io_wr = w;
        addr = {28'h4000000, s, 2'b00};
        wdata = d;
    endtask

    task automatic rd_chk(string nm, logic [1:0] s, logic [31:0] exp);
        acc(1, 0, s, 0);
        #1 chk(nm, io_out, exp);
        tick;
        idle;
    endtask

    task automatic wr_reg(logic [1:0] s, logic [31:0] d);
        acc(0, 1, s, d);
        tick;
        idle;
    endtask

    task automatic push(logic [31:0] d);
        in_valid = 1; in_data = d;
        tick;
        in_valid = 0;
    endtask

    initial begin
        v[0] = '{1, 2, 0, 0, 32'h2, 1};
        for (int i = 0; i < 8; i++) v[1+i] = '{0, 0, 1, 32'h10 + i, 0, 1};
        v[9]  = '{1, 2, 1, 32'h99, 32'h204, 0};
        v[10] = '{1, 2, 0, 0, 32'h204, 0};
        for (int i = 0; i < 8; i++) v[11+i] = '{1, 0, 0, 0, 32'h10 + i, i != 0};
        v[19] = '{1, 2, 0, 0, 32'h2, 1};

        tick;
        chk("rst intr", intr, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst io_out", io_out, 0);
        rst = 0;
        tick;

        for (int k = 0; k < 20; k++) begin
            acc(v[k].rd, 0, v[k].sel, 0);
            in_valid = v[k].iv;
            in_data  = v[k].idata;
            #1;
            chk($sformatf("vec%0d io_out", k), io_out, v[k].exp_out);
            chk($sformatf("vec%0d in_ready", k), in_ready, v[k].exp_rdy);
            chk($sformatf("vec%0d intr", k), intr, 0);
            tick;
            idle;
        end

        for (int i = 0; i < 8; i++) push(32'h20 + i);
        acc(1, 0, 0, 0);
        in_valid = 1; in_data = 32'hEE;
        #1;
        chk("full pop data", io_out, 32'h20);
        chk("full push blocked", in_ready, 0);
        tick;
        idle;
        rd_chk("count 7", 2, 32'h1C0);
        for (int i = 1; i < 8; i++) rd_chk($sformatf("drain%0d", i), 0, 32'h20 + i);
        rd_chk("drained status", 2, 32'h2);

        push(32'h100);
        for (int k = 1; k <= 20; k++) begin
            acc(1, 0, 0, 0);
            in_valid = 1; in_data = 32'h100 + k;
            #1 chk($sformatf("wrap%0d", k), io_out, 32'h100 + k - 1);
            tick;
            idle;
        end
        rd_chk("wrap last", 0, 32'h114);
        rd_chk("wrap status", 2, 32'h2);

        wr_reg(3, 1);
        push(32'hAB);
        chk("intr after push edge", intr, 0);
        tick;
        chk("intr raised", intr, 1);
        rd_chk("int status", 2, 32'h41);
        intr_ack = 1;
        #1 chk("intr before ack edge", intr, 1);
        tick;
        intr_ack = 0;
        chk("intr acked", intr, 0);
        intr_ack = 1;
        tick;
        intr_ack = 0;
        chk("service ack ignored", intr, 0);
        rd_chk("int data", 0, 32'hAB);
        tick;
        push(32'hCD);
        chk("re-raise pending", intr, 0);
        tick;
        chk("intr re-raised", intr, 1);
        wr_reg(3, 0);
        chk("intr after ie clear write", intr, 1);
        tick;
        chk("intr dropped by ie", intr, 0);

        out_ready = 0;
        wr_reg(1, 32'h55);
        wr_reg(1, 32'h66);
        chk("out_data kept", out_data, 32'h55);
        chk("out_valid held", out_valid, 1);
        rd_chk("overflow status", 2, 32'h58);
        rd_chk("read DATA_OUT", 1, 32'h55);
        out_ready = 1;
        #1 chk("out_valid before accept", out_valid, 1);
        tick;
        chk("out_valid after accept", out_valid, 0);
        wr_reg(3, 4);
        rd_chk("overflow cleared", 2, 32'h40);
        wr_reg(1, 32'h77);
        acc(0, 1, 1, 32'h88);
        tick;
        idle;
        out_ready = 0;
        chk("accept+write data", out_data, 32'h88);
        chk("accept+write valid", out_valid, 1);
        rd_chk("no overflow", 2, 32'h48);

        acc(0, 1, 3, 2);
        in_valid = 1; in_data = 32'hEF;
        tick;
        idle;
        rd_chk("flush status", 2, 32'h0A);
        rd_chk("underflow read", 0, 32'h0);
        rd_chk("underflow status", 2, 32'h2A);
        push(32'h31);
        rd_chk("after underflow", 0, 32'h31);

        wr_reg(3, 1);
        push(32'h42);
        tick;
        chk("pre-rst intr", intr, 1);
        chk("pre-rst out_valid", out_valid, 1);
        #2 rst = 1;
        #1;
        chk("async rst intr", intr, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst out_data", out_data, 0);
        chk("async rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        tick;
        rd_chk("post-rst status", 2, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
